// File: rtl/stream_24_pkg.sv
`default_nettype none
// ============================================================================
// Module   : stream_24_pkg
// Purpose  : Shared constants, state encodings and trailer helper for the
//            24-bit stream framer.
// Contents : DATA_W / LEN_W widths, trailer field positions, write-side and
//            output-side state enums, make_trailer() helper.
// Revision : 1.0 - initial release
// ============================================================================
package stream_24_pkg;

  localparam int DATA_W = 24;
  localparam int LEN_W  = 16;

  // One status word per packet: {truncated, length}
  localparam int STAT_W = LEN_W + 1;

  // Trailer beat layout: {trunc, 7'b0, len[15:0]}
  localparam int TRL_TRUNC_BIT = 23;
  localparam int TRL_LEN_MSB   = 15;
  localparam int TRL_LEN_LSB   = 0;

  typedef enum logic [0:0] {
    WR_ACCEPT = 1'b0,
    WR_DROP   = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    OUT_DATA  = 1'b0,
    OUT_TRAIL = 1'b1
  } out_state_t;

  function automatic logic [DATA_W-1:0] make_trailer(input logic [STAT_W-1:0] stat);
    logic [DATA_W-1:0] t;
    t = '0;
    t[TRL_TRUNC_BIT]           = stat[STAT_W-1];
    t[TRL_LEN_MSB:TRL_LEN_LSB] = stat[LEN_W-1:0];
    return t;
  endfunction

endpackage
`default_nettype wire

// File: rtl/stream_24_framer_if.sv
`default_nettype none
// ============================================================================
// Module   : stream_24_framer_if
// Purpose  : Output stream bundle of the 24-bit framer.
// Signals  : m_data (24) word, m_valid, m_ready, m_last.
// Modports : master (framer side), slave (downstream consumer).
// Revision : 1.0 - initial release
// ============================================================================
interface stream_24_framer_if;
  import stream_24_pkg::*;

  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;
  logic              m_last;

  modport master (output m_data, output m_valid, output m_last, input m_ready);
  modport slave  (input m_data, input m_valid, input m_last, output m_ready);

endinterface
`default_nettype wire

// File: rtl/stream_24_fifo.sv
`default_nettype none
// ============================================================================
// Module   : stream_24_fifo
// Purpose  : Register-array FIFO with first-word-fall-through read and a
//            port that forces the MSB of the most recently written entry.
// Ports    : clk, reset (sync, active high), wr_en/wr_data, mark_last,
//            rd_en/rd_data (FWFT head), empty, full.
// Revision : 1.0 - initial release
// ============================================================================
module stream_24_fifo #(
  parameter int WIDTH = 25,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             mark_last,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  // Extra MSB distinguishes full from empty when the index bits match
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;
  logic [AW-1:0]    newest;

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_wr  = wr_en & ~full;
  assign do_rd  = rd_en & ~empty;
  assign newest = wr_ptr[AW-1:0] - AW'(1);

  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_rd) rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // Writing and marking never coincide: marking only happens on a dropped word
  always_ff @(posedge clk) begin
    if (do_wr) begin
      mem[wr_ptr[AW-1:0]] <= wr_data;
    end else if (mark_last && !empty) begin
      mem[newest][WIDTH-1] <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/stream_24_framer.sv
`default_nettype none
// ============================================================================
// Module   : stream_24_framer
// Purpose  : Packet framer behind a 32->24 gearbox. Buffers words in a FWFT
//            FIFO, truncates or discards packets on overflow (no upstream
//            backpressure) and flags drops in ovf_sticky.
// Ports    : clk_out, reset (sync, active high), data_in[23:0], data_in_last,
//            data_in_en, ovf_clr, ovf_sticky, m_if (master: m_data, m_valid,
//            m_ready, m_last).
// Config   : STREAM24_TRAILER_EN - append a {trunc,7'b0,len} trailer beat
//            after every packet, using a second (status) FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module stream_24_framer
  import stream_24_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic              clk_out,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_last,
  input  logic              data_in_en,
  input  logic              ovf_clr,
  output logic              ovf_sticky,
  stream_24_framer_if.master m_if
);

  wr_state_t         wr_state, wr_state_nxt;
  logic [LEN_W-1:0]  len_cnt, len_nxt, len_inc;
  logic              full;
  logic              drop;
  logic              dfifo_wr, dfifo_mark, dfifo_rd, dfifo_empty, dfifo_full;
  logic [DATA_W:0]   dfifo_rdata;
  logic [DATA_W-1:0] m_data;
  logic              m_valid, m_last, m_ready;

  assign m_ready        = m_if.m_ready;
  assign m_if.m_data    = m_data;
  assign m_if.m_valid   = m_valid;
  assign m_if.m_last    = m_last;

  assign len_inc = (len_cnt == '1) ? len_cnt : len_cnt + LEN_W'(1);

  stream_24_fifo #(.WIDTH(DATA_W + 1), .DEPTH(FIFO_DEPTH)) u_data_fifo (
    .clk       (clk_out),
    .reset     (reset),
    .wr_en     (dfifo_wr),
    .wr_data   ({data_in_last, data_in}),
    .mark_last (dfifo_mark),
    .rd_en     (dfifo_rd),
    .rd_data   (dfifo_rdata),
    .empty     (dfifo_empty),
    .full      (dfifo_full)
  );

  // ---------------- write side ----------------
  always_ff @(posedge clk_out) begin
    if (reset) begin
      wr_state   <= WR_ACCEPT;
      len_cnt    <= '0;
      ovf_sticky <= 1'b0;
    end else begin
      wr_state <= wr_state_nxt;
      len_cnt  <= len_nxt;
      if (drop)         ovf_sticky <= 1'b1;
      else if (ovf_clr) ovf_sticky <= 1'b0;
    end
  end

  always_comb begin
    wr_state_nxt = wr_state;
    len_nxt      = len_cnt;
    dfifo_wr     = 1'b0;
    dfifo_mark   = 1'b0;
    drop         = 1'b0;
    if (data_in_en) begin
      case (wr_state)
        WR_ACCEPT: begin
          if (!full) begin
            dfifo_wr = 1'b1;
            len_nxt  = data_in_last ? '0 : len_inc;
          end else begin
            // A partly stored packet is closed at its newest word; an
            // unstarted one vanishes completely.
            drop       = 1'b1;
            dfifo_mark = (len_cnt != '0);
            len_nxt    = '0;
            if (!data_in_last) wr_state_nxt = WR_DROP;
          end
        end
        WR_DROP: begin
          drop = 1'b1;
          if (data_in_last) wr_state_nxt = WR_ACCEPT;
        end
        default: wr_state_nxt = WR_ACCEPT;
      endcase
    end
  end

`ifdef STREAM24_TRAILER_EN
  // ---------------- status FIFO + trailer output ----------------
  out_state_t        out_state, out_state_nxt;
  logic              sfifo_wr, sfifo_rd, sfifo_empty, sfifo_full;
  logic [STAT_W-1:0] sfifo_wdata, sfifo_rdata;

  // The status FIFO only fills with closed packets, so it can never be full
  // while a packet is open; blocking on it only rejects a packet's first word.
  assign full        = dfifo_full | sfifo_full;
  assign sfifo_wr    = (dfifo_wr & data_in_last) | dfifo_mark;
  assign sfifo_wdata = dfifo_mark ? {1'b1, len_cnt} : {1'b0, len_inc};

  stream_24_fifo #(.WIDTH(STAT_W), .DEPTH(FIFO_DEPTH)) u_stat_fifo (
    .clk       (clk_out),
    .reset     (reset),
    .wr_en     (sfifo_wr),
    .wr_data   (sfifo_wdata),
    .mark_last (1'b0),
    .rd_en     (sfifo_rd),
    .rd_data   (sfifo_rdata),
    .empty     (sfifo_empty),
    .full      (sfifo_full)
  );

  always_ff @(posedge clk_out) begin
    if (reset) out_state <= OUT_DATA;
    else       out_state <= out_state_nxt;
  end

  always_comb begin
    out_state_nxt = out_state;
    dfifo_rd      = 1'b0;
    sfifo_rd      = 1'b0;
    m_valid       = 1'b0;
    m_data        = '0;
    m_last        = 1'b0;
    case (out_state)
      OUT_DATA: begin
        if (!dfifo_empty) begin
          m_valid = 1'b1;
          m_data  = dfifo_rdata[DATA_W-1:0];
          if (m_ready) begin
            dfifo_rd = 1'b1;
            if (dfifo_rdata[DATA_W]) out_state_nxt = OUT_TRAIL;
          end
        end
      end
      OUT_TRAIL: begin
        if (!sfifo_empty) begin
          m_valid = 1'b1;
          m_data  = make_trailer(sfifo_rdata);
          m_last  = 1'b1;
          if (m_ready) begin
            sfifo_rd      = 1'b1;
            out_state_nxt = OUT_DATA;
          end
        end
      end
      default: out_state_nxt = OUT_DATA;
    endcase
  end
`else
  // ---------------- plain data output ----------------
  assign full = dfifo_full;

  always_comb begin
    m_valid  = !dfifo_empty;
    m_data   = m_valid ? dfifo_rdata[DATA_W-1:0] : '0;
    m_last   = m_valid & dfifo_rdata[DATA_W];
    dfifo_rd = m_valid & m_ready;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_stream_24_framer.sv
`default_nettype none
// ============================================================================
// Module   : tb_stream_24_framer
// Purpose  : Self-checking bench for stream_24_framer. A queue-based packet
//            model predicts every output beat; directed scenarios also pin
//            the observed beat sequences to hand-computed literals.
// Config   : honours STREAM24_TRAILER_EN like the design.
// Revision : 1.0 - initial release
// ============================================================================
module tb_stream_24_framer;

  localparam int DEPTH = 16;
`ifdef STREAM24_TRAILER_EN
  localparam bit TRL = 1'b1;
`else
  localparam bit TRL = 1'b0;
`endif

  logic        clk_out = 1'b0;
  logic        reset = 1'b1;
  logic [23:0] data_in = '0;
  logic        data_in_last = 1'b0;
  logic        data_in_en = 1'b0;
  logic        ovf_clr = 1'b0;
  logic        m_ready = 1'b0;
  logic        ovf_sticky;

  stream_24_framer_if m_if ();
  assign m_if.m_ready = m_ready;

  stream_24_framer #(.FIFO_DEPTH(DEPTH)) dut (
    .clk_out      (clk_out),
    .reset        (reset),
    .data_in      (data_in),
    .data_in_last (data_in_last),
    .data_in_en   (data_in_en),
    .ovf_clr      (ovf_clr),
    .ovf_sticky   (ovf_sticky),
    .m_if         (m_if)
  );

  always #5 clk_out = ~clk_out;

  int vectors = 0;
  int miscompares = 0;

  typedef struct { logic [23:0] data; logic last; logic trl; } beat_t;
  typedef struct { logic [23:0] data; logic last; } obs_t;

  beat_t mq[$];          // expected output beats, oldest first
  int    mlen;           // words of the open packet
  bit    mdrop;          // discarding until next last
  bit    movf;
  obs_t  obs[$];         // beats the DUT actually transferred
  obs_t  expq[$];        // literal expectations for a scenario

  function automatic int sat16(input int v);
    return (v > 65535) ? 65535 : v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  always @(posedge clk_out) begin : model
    int  dcnt, scnt;
    bit  full, xfer, drop;
    if (reset) begin
      mq.delete();
      mlen  = 0;
      mdrop = 0;
      movf  = 0;
    end else begin
      dcnt = 0;
      scnt = 0;
      drop = 0;
      foreach (mq[i]) begin
        if (mq[i].trl) scnt++;
        else           dcnt++;
      end
      full = (dcnt == DEPTH) || (TRL && scnt == DEPTH);
      xfer = (mq.size() > 0) && m_ready;
      if (data_in_en) begin
        if (mdrop) begin
          drop = 1;
          if (data_in_last) mdrop = 0;
        end else if (!full) begin
          mq.push_back('{data_in, data_in_last, 1'b0});
          if (data_in_last) begin
            if (TRL) mq.push_back('{{8'h00, 16'(sat16(mlen + 1))}, 1'b1, 1'b1});
            mlen = 0;
          end else begin
            mlen = sat16(mlen + 1);
          end
        end else begin
          drop = 1;
          if (mlen > 0) begin
            mq[mq.size()-1].last = 1'b1;
            if (TRL) mq.push_back('{{8'h80, 16'(mlen)}, 1'b1, 1'b1});
          end
          mlen = 0;
          if (!data_in_last) mdrop = 1;
        end
      end
      if (xfer) void'(mq.pop_front());
      if (drop)         movf = 1;
      else if (ovf_clr) movf = 0;
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk_out) begin : compare
    logic exp_last;
    chk("m_valid", 32'(m_if.m_valid), 32'(mq.size() > 0));
    chk("ovf_sticky", 32'(ovf_sticky), 32'(movf));
    if (mq.size() > 0) begin
      exp_last = mq[0].trl | (!TRL & mq[0].last);
      chk("m_data", 32'(m_if.m_data), 32'(mq[0].data));
      chk("m_last", 32'(m_if.m_last), 32'(exp_last));
    end else begin
      chk("m_data_idle", 32'(m_if.m_data), 32'h0);
      chk("m_last_idle", 32'(m_if.m_last), 32'h0);
    end
    if (m_if.m_valid && m_ready) obs.push_back('{m_if.m_data, m_if.m_last});
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk_out);
    #1;
  endtask

  task automatic send(input logic [23:0] d, input bit l);
    data_in      = d;
    data_in_last = l;
    data_in_en   = 1'b1;
    tick();
    data_in_en   = 1'b0;
    data_in_last = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    m_ready = 1'b1;
    n = 0;
    while ((m_if.m_valid || mq.size() > 0) && n < 300) begin
      tick();
      n++;
    end
    if (m_if.m_valid) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_drain_timeout: m_valid still 1 after %0d cycles", name, n);
    end
    tick();
  endtask

  task automatic exp_push(input logic [23:0] d, input bit l);
    expq.push_back('{d, l});
  endtask

  // expected data word (last bit only visible without trailer) + optional trailer
  task automatic exp_word(input logic [23:0] d, input bit pkt_end, input logic [23:0] trailer);
    exp_push(d, pkt_end && !TRL);
    if (pkt_end && TRL) exp_push(trailer, 1'b1);
  endtask

  task automatic check_obs(input string name);
    chk({name, "_count"}, 32'(obs.size()), 32'(expq.size()));
    for (int i = 0; i < expq.size() && i < obs.size(); i++) begin
      chk($sformatf("%s_data[%0d]", name, i), 32'(obs[i].data), 32'(expq[i].data));
      chk($sformatf("%s_last[%0d]", name, i), 32'(obs[i].last), 32'(expq[i].last));
    end
    obs.delete();
    expq.delete();
  endtask

  task automatic clear_ovf();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  initial begin
    reset = 1'b1;
    repeat (3) tick();
    chk("reset_m_valid", 32'(m_if.m_valid), 32'h0);
    chk("reset_m_data", 32'(m_if.m_data), 32'h0);
    chk("reset_m_last", 32'(m_if.m_last), 32'h0);
    chk("reset_ovf", 32'(ovf_sticky), 32'h0);
    reset = 1'b0;
    tick();

    // 5-word packet, consumer always ready
    m_ready = 1'b1;
    for (int i = 1; i <= 5; i++) send(24'(i), i == 5);
    drain("p5");
    for (int i = 1; i <= 5; i++) exp_word(24'(i), i == 5, 24'h000005);
    check_obs("p5");
    chk("p5_ovf", 32'(ovf_sticky), 32'h0);

    // 20-word packet into a stalled 16-entry FIFO: truncated at word 16
    m_ready = 1'b0;
    for (int i = 1; i <= 20; i++) send(24'(i), i == 20);
    chk("trunc_ovf", 32'(ovf_sticky), 32'h1);
    drain("trunc");
    for (int i = 1; i <= 16; i++) exp_word(24'(i), i == 16, 24'h800010);
    check_obs("trunc");
    clear_ovf();
    chk("trunc_ovf_clr", 32'(ovf_sticky), 32'h0);

    // FIFO full of closed 1-word packets; a new 3-word packet vanishes
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(24'h000100 + 24'(i), 1'b1);
    chk("full_ovf_before", 32'(ovf_sticky), 32'h0);
    send(24'h000200, 1'b0);
    send(24'h000201, 1'b0);
    send(24'h000202, 1'b1);
    chk("discard_ovf", 32'(ovf_sticky), 32'h1);
    drain("discard");
    for (int i = 0; i < 16; i++) exp_word(24'h000100 + 24'(i), 1'b1, 24'h000001);
    check_obs("discard");
    clear_ovf();

    // Back-to-back single-word packets with a toggling consumer
    m_ready = 1'b1;
    data_in = 24'h00000A; data_in_last = 1'b1; data_in_en = 1'b1;
    tick();
    m_ready = 1'b0;
    data_in = 24'h00000B;
    tick();
    data_in_en = 1'b0; data_in_last = 1'b0;
    for (int i = 0; i < 12; i++) begin
      m_ready = ~m_ready;
      tick();
    end
    drain("b2b");
    exp_word(24'h00000A, 1'b1, 24'h000001);
    exp_word(24'h00000B, 1'b1, 24'h000001);
    check_obs("b2b");
    chk("b2b_ovf", 32'(ovf_sticky), 32'h0);

    // Reset in the middle of a packet
    m_ready = 1'b0;
    send(24'h000011, 1'b0);
    send(24'h000012, 1'b0);
    send(24'h000013, 1'b0);
    chk("midrst_valid_before", 32'(m_if.m_valid), 32'h1);
    reset = 1'b1;
    tick();
    chk("midrst_valid", 32'(m_if.m_valid), 32'h0);
    chk("midrst_data", 32'(m_if.m_data), 32'h0);
    reset = 1'b0;
    m_ready = 1'b1;
    send(24'h000021, 1'b0);
    send(24'h000022, 1'b1);
    drain("midrst");
    exp_word(24'h000021, 1'b0, 24'h0);
    exp_word(24'h000022, 1'b1, 24'h000002);
    check_obs("midrst");

    // Drop coinciding with ovf_clr keeps the flag set
    m_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(24'h000300 + 24'(i), i == 15);
    send(24'h000400, 1'b1);
    chk("clr_race_ovf_set", 32'(ovf_sticky), 32'h1);
    ovf_clr = 1'b1;
    send(24'h000401, 1'b1);
    ovf_clr = 1'b0;
    chk("clr_race_ovf_hold", 32'(ovf_sticky), 32'h1);
    clear_ovf();
    chk("clr_race_ovf_cleared", 32'(ovf_sticky), 32'h0);
    drain("clr_race");
    for (int i = 0; i < 16; i++) exp_word(24'h000300 + 24'(i), i == 15, 24'h000010);
    check_obs("clr_race");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/stream_24_framer.md
STREAM_24_FRAMER -- requirements
Module: stream_24_framer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, data FIFO entries (power of 2, 4..256).
REQ-002 SHALL have port clk_out  in  1  single clock, consumer side of 32->24 gearbox.
REQ-003 SHALL have port reset  in  1  synchronous, active-high reset sampled on clk_out.
REQ-004 SHALL have port data_in  in  24  gearbox output word.
REQ-005 SHALL have port data_in_last  in  1  final word of packet, qualified by data_in_en.
REQ-006 SHALL have port data_in_en  in  1  word valid; no backpressure possible upstream.
REQ-007 SHALL have port m_data  out  24  output word.
REQ-008 SHALL have port m_valid  out  1  output word valid.
REQ-009 SHALL have port m_ready  in  1  downstream accept; transfer = m_valid & m_ready.
REQ-010 SHALL have port m_last  out  1  final output beat of packet.
REQ-011 SHALL have port ovf_clr  in  1  clears ovf_sticky.
REQ-012 SHALL have port ovf_sticky  out  1  set on any dropped input word.

Function
REQ-013 SHALL write {data_in_last,data_in} into the FIFO when data_in_en, FIFO not full, and write state ACCEPT.
REQ-014 SHALL present FIFO head first-word-fall-through: word written at edge N gives m_valid=1 from edge N onward.
REQ-015 SHALL hold m_data/m_last stable while m_valid & !m_ready; m_data=0, m_last=0 whenever m_valid=0.
REQ-016 SHALL evaluate full from registered pointers: write while full is dropped even if a read occurs that cycle.
REQ-017 SHALL count accepted words of the current packet in 16-bit len_cnt, saturating at 0xFFFF, cleared after last is written.
REQ-018 On drop (data_in_en & full) with len_cnt>0: SHALL set last bit of newest FIFO entry, flag packet truncated, enter DROP unless dropped word had data_in_last.
REQ-019 On drop with len_cnt==0: SHALL discard the whole packet, no marking, no trailer, enter DROP unless data_in_last.
REQ-020 In DROP: SHALL discard all words up to and including next data_in_last, then return to ACCEPT.
REQ-021 SHALL set ovf_sticky the cycle after any drop; ovf_clr clears it; set wins over simultaneous clear.
REQ-022 Output FSM states SHALL be DATA and TRAIL; DATA->TRAIL on transfer of a last-marked word (trailer build only); TRAIL->DATA on trailer transfer.

Reset
REQ-023 SHALL, on reset (including mid-packet), empty both FIFOs, zero len_cnt, enter ACCEPT/DATA, drive m_valid=0, m_last=0, m_data=0, ovf_sticky=0 the following cycle.
REQ-024 After reset deassertion SHALL treat the next word as start of a new packet.

Configuration
REQ-025 Macro STREAM24_TRAILER_EN defined: after each packet's last data word SHALL emit one trailer beat {trunc,7'b0,len[15:0]} with m_last=1 on the trailer only; status FIFO (FIFO_DEPTH entries) full also counts as full for REQ-016.
REQ-026 Macro undefined: no status FIFO, no TRAIL state; m_last = stored last bit; truncation visible only via ovf_sticky.

Structure
REQ-027 Package stream_24_pkg SHALL hold DATA_W=24, LEN_W=16, trailer field positions, write/output state encodings.
REQ-028 Data FIFO SHALL be sub-module stream_24_fifo (register array, FWFT, mark-newest-last port); status FIFO reuses it at width 17.

Verification
REQ-029 Packet 5 words 0x000001..0x000005, m_ready=1 -> same 5 words, m_last on 5th; trailer 0x000005 if enabled.
REQ-030 FIFO_DEPTH=16, m_ready=0, 20-word packet -> 16 words stored, 16th marked last, ovf_sticky=1, trailer 0x800010.
REQ-031 Full FIFO of closed packets, new 3-word packet -> discarded entirely, no trailer, ovf_sticky=1.
REQ-032 Back-to-back 1-word packets 0xA, 0xB, m_ready toggling 1/0 -> 0xA,trailer 0x000001,0xB,trailer 0x000001 in order, no drops.
REQ-033 Reset asserted mid-packet after 3 words -> m_valid=0 next cycle; following 2-word packet output alone with len 2.
REQ-034 ovf_clr and new drop same cycle -> ovf_sticky remains 1.
